fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 22: PC/memory address width.
REQ-002 Parameter DATA_W, default 32: bus and instruction width.
REQ-003 Parameter TIMEOUT, default 8, legal range 1-15: maximum MEM_WAIT cycles before a fetch error.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request one instruction fetch; sampled only in IDLE.
REQ-008 flush  input  1  synchronous abort of any fetch in progress.
REQ-009 bus_in  input  DATA_W  shared data bus; carries the PC while pc_out is high.
REQ-010 pc_out  output  1  commands the PC to drive the bus.
REQ-011 pc_increment  output  1  one-cycle pulse that commands the PC to advance by one.
REQ-012 mem_addr  output  ADDR_W  instruction memory address.
REQ-013 mem_rd  output  1  memory read request.
REQ-014 mem_ready  input  1  memory read data valid this cycle.
REQ-015 mem_rdata  input  DATA_W  memory read data.
REQ-016 ir  output  DATA_W  instruction register.
REQ-017 ir_valid  output  1  one-cycle pulse: ir was updated.
REQ-018 fetch_err  output  1  one-cycle pulse: fetch timed out.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have exactly five states: IDLE, PC_RD, MEM_WAIT, DONE, ERR.
REQ-021 All outputs SHALL be registered or decoded from state only (Moore); there SHALL be no combinational path from an input to an output.
REQ-022 IDLE SHALL move to PC_RD on a clock edge where start=1 and flush=0, and SHALL otherwise remain in IDLE.
REQ-023 PC_RD SHALL last exactly one cycle with pc_out=1; on its closing edge the block SHALL load mar with bus_in[ADDR_W-1:0], ignore bus_in[DATA_W-1:ADDR_W], and move to MEM_WAIT.
REQ-024 MEM_WAIT SHALL hold mem_rd=1 and mem_addr=mar, and SHALL increment the wait counter on each cycle spent in MEM_WAIT.
REQ-025 In MEM_WAIT, an edge with mem_ready=1 SHALL load ir with mem_rdata and move the FSM to DONE.
REQ-026 In MEM_WAIT, an edge where mem_ready=0 and the wait counter equals TIMEOUT-1 SHALL move the FSM to ERR.
REQ-027 DONE SHALL last one cycle with ir_valid=1 and pc_increment=1, then move to IDLE.
REQ-028 ERR SHALL last one cycle with fetch_err=1, pc_increment=0, and ir unchanged, then move to IDLE.
REQ-029 Minimum latency SHALL be: start sampled at edge k, pc_out high in cycle k+1, mem_rd high from cycle k+2, and ir_valid high in cycle k+3 when mem_ready=1 at the first MEM_WAIT edge.
REQ-030 mem_addr SHALL equal mar in every state.
REQ-031 ir SHALL hold its value between DONE states.
REQ-032 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-033 flush=1 on any edge SHALL force IDLE, SHALL clear the wait counter, and SHALL leave ir and mar unchanged.
REQ-034 flush=1 SHALL take priority over start, over mem_ready, and over timeout on the same edge; no ir_valid, fetch_err or pc_increment pulse SHALL follow.
REQ-035 mem_ready outside MEM_WAIT SHALL be ignored.
REQ-036 The wait counter SHALL be cleared on entry to MEM_WAIT and SHALL never wrap.
REQ-037 Address wrap SHALL be the PC's responsibility; mar = {ADDR_W{1'b1}} SHALL be fetched normally.

Reset
REQ-038 On rst_n=0 the block SHALL asynchronously enter IDLE and clear mar, ir and the wait counter to 0.
REQ-039 While rst_n=0, pc_out, pc_increment, mem_rd, ir_valid, fetch_err and busy SHALL all be 0.
REQ-040 Reset asserted mid-fetch SHALL abandon the fetch without any pc_increment pulse.
REQ-041 The first edge after reset release SHALL be treated as an ordinary IDLE edge.

Structure
REQ-042 Shared package fetch_pkg SHALL hold the state enum type and the ADDR_W and DATA_W defaults.
REQ-043 Sub-module wait_timer SHALL implement the 4-bit wait counter, with inputs clear and enable and output expired.

Verification
REQ-044 Zero wait: bus_in=32'h0000_0010, start at edge 0, mem_ready=1 -> pc_out in cycle 1, mem_addr=22'h10, mem_rd in cycle 2, ir=mem_rdata=32'hDEAD_BEEF with ir_valid and pc_increment in cycle 3.
REQ-045 Wait states: mem_ready rises after 3 MEM_WAIT cycles -> ir_valid in cycle 6, mem_rd high in cycles 2-5.
REQ-046 Timeout: TIMEOUT=8, mem_ready held 0 -> fetch_err in cycle 10, ir unchanged, no pc_increment, busy=0 in cycle 11.
REQ-047 Flush race: flush=1 and mem_ready=1 on the same edge -> IDLE, ir unchanged, no pulses.
REQ-048 Upper-bit mask: bus_in=32'hFFC0_0005 -> mem_addr=22'h000005.
REQ-049 Mid-fetch reset: rst_n low in MEM_WAIT -> all outputs 0 immediately; start while busy -> no second fetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and width defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 22;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PC_RD    = 3'd1,
    MEM_WAIT = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } state_t;

endpackage

// File: rtl/wait_timer.sv
// 4-bit saturating wait counter; expired flags the last allowed wait cycle.
module wait_timer #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (enable && count != 4'hF) begin
      count <= count + 4'd1;
    end
  end

  assign expired = (count == 4'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Single-instruction fetch FSM: reads the PC off the shared bus, then waits on memory.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int DATA_W  = FETCH_DATA_W,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] bus_in,
  output logic              pc_out,
  output logic              pc_increment,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              fetch_err,
  output logic              busy
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] mar;
  logic              expired;
  logic              unused_bus_hi;

  // The PC only occupies the low ADDR_W bits of the bus.
  assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_next = PC_RD;
        PC_RD:    state_next = MEM_WAIT;
        MEM_WAIT: begin
          if (mem_ready)    state_next = DONE;
          else if (expired) state_next = ERR;
        end
        DONE:     state_next = IDLE;
        ERR:      state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // mar and ir only change on completed steps; flush leaves both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
      ir  <= '0;
    end else begin
      if (state == PC_RD && !flush) begin
        mar <= bus_in[ADDR_W-1:0];
      end
      if (state == MEM_WAIT && mem_ready && !flush) begin
        ir <= mem_rdata;
      end
    end
  end

  // Held clear outside MEM_WAIT so every wait phase starts from zero.
  wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush || state != MEM_WAIT),
    .enable  (state == MEM_WAIT),
    .expired (expired)
  );

  assign pc_out       = (state == PC_RD);
  assign mem_rd       = (state == MEM_WAIT);
  assign ir_valid     = (state == DONE);
  assign pc_increment = (state == DONE);
  assign fetch_err    = (state == ERR);
  assign busy         = (state != IDLE);
  assign mem_addr     = mar;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized fetch scenarios checked against a cycle-schedule model.
module tb_fetch_unit;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          flush;
  logic [DW-1:0] bus_in;
  logic          pc_out;
  logic          pc_increment;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic          fetch_err;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] exp_ir;
  logic [AW-1:0] exp_mar;

  fetch_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .bus_in       (bus_in),
    .pc_out       (pc_out),
    .pc_increment (pc_increment),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .fetch_err    (fetch_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " pc_out"}, pc_out, 0);
    chk({tag, " pc_increment"}, pc_increment, 0);
    chk({tag, " mem_rd"}, mem_rd, 0);
    chk({tag, " ir_valid"}, ir_valid, 0);
    chk({tag, " fetch_err"}, fetch_err, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  // One fetch: d = MEM_WAIT cycles before mem_ready, f = edge carrying flush (-1 none).
  // Cycle c is the cycle after edge c; start is sampled at edge 0.
  task automatic run_fetch(input logic [AW-1:0] pc, input logic [DW-AW-1:0] hi,
                           input logic [DW-1:0] data, input int d, input int f);
    bit done_ok;
    int normal_end;
    int last_wait;
    int end_c;
    done_ok    = (d < T);
    normal_end = done_ok ? 3 + d : 2 + T;
    last_wait  = done_ok ? 2 + d : 1 + T;
    end_c      = (f >= 0) ? f + 1 : normal_end;
    bus_in     = {hi, pc};
    mem_rdata  = data;
    start      = 1'b1;
    flush      = (f == 0);
    mem_ready  = 1'($urandom_range(0, 1));
    step();
    for (int c = 1; c <= end_c; c++) begin
      bit act;
      bit e_rd;
      bit e_end;
      act = (f < 0) || (c <= f);
      if (c == 2 && (f < 0 || f > 1)) exp_mar = pc;
      if (c == normal_end && done_ok && act) exp_ir = data;
      e_rd  = act && c >= 2 && c <= last_wait;
      e_end = act && c == normal_end;
      chk($sformatf("c%0d pc_out", c), pc_out, act && c == 1);
      chk($sformatf("c%0d mem_rd", c), mem_rd, e_rd);
      chk($sformatf("c%0d ir_valid", c), ir_valid, e_end && done_ok);
      chk($sformatf("c%0d pc_increment", c), pc_increment, e_end && done_ok);
      chk($sformatf("c%0d fetch_err", c), fetch_err, e_end && !done_ok);
      chk($sformatf("c%0d busy", c), busy, act);
      chk($sformatf("c%0d mem_addr", c), mem_addr, exp_mar);
      chk($sformatf("c%0d ir", c), ir, exp_ir);
      start     = (c < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      flush     = (c == f);
      mem_ready = e_rd ? (c - 2 == d) : 1'($urandom_range(0, 1));
      step();
    end
    start     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    chk("post busy", busy, 0);
    chk("post pc_out", pc_out, 0);
    chk("post ir", ir, exp_ir);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    bus_in    = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    exp_ir    = '0;
    exp_mar   = '0;

    // Reset state; start is ignored while reset is held.
    start = 1'b1;
    step();
    step();
    chk_idle_outputs("reset");
    chk("reset mem_addr", mem_addr, 0);
    chk("reset ir", ir, 0);
    start = 1'b0;
    rst_n = 1'b1;

    // Zero-wait fetch on the first edge after reset release.
    run_fetch(22'h000010, 10'h000, 32'hDEAD_BEEF, 0, -1);
    chk("zero-wait ir", ir, 32'hDEAD_BEEF);

    // Three wait states.
    run_fetch(22'h000123, 10'h155, 32'h1234_5678, 3, -1);

    // Timeout: mem_ready never arrives inside MEM_WAIT.
    run_fetch(22'h000200, 10'h000, 32'hBAD0_BAD0, 20, -1);
    chk("timeout ir kept", ir, 32'h1234_5678);

    // Flush races mem_ready on the last MEM_WAIT edge.
    run_fetch(22'h000300, 10'h000, 32'hCAFE_F00D, 2, 4);
    // Flush together with start.
    run_fetch(22'h000400, 10'h000, 32'h0BAD_CAFE, 0, 0);
    // Flush on the PC_RD edge leaves mar alone.
    run_fetch(22'h000500, 10'h000, 32'h0BAD_CAFE, 0, 1);
    // Flush on the timeout edge.
    run_fetch(22'h000600, 10'h000, 32'h0BAD_CAFE, 9, 1 + T);

    // Upper bus bits are masked off the address.
    run_fetch(22'h000005, 10'h3FF, 32'h5555_AAAA, 1, -1);
    chk("mask mem_addr", mem_addr, 22'h000005);

    // All-ones address fetched normally.
    run_fetch(22'h3FFFFF, 10'h2AA, 32'hFFFF_0001, 2, -1);

    // Mid-fetch reset while in MEM_WAIT.
    bus_in    = 32'h0000_0777;
    mem_rdata = 32'h7777_7777;
    start     = 1'b1;
    step();
    start = 1'b1;
    step();
    chk("midrst pre mem_rd", mem_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst ir", ir, 0);
    exp_ir  = '0;
    exp_mar = '0;
    start   = 1'b0;
    step();
    chk("midrst hold pc_increment", pc_increment, 0);
    rst_n = 1'b1;
    step();
    chk("midrst after busy", busy, 0);

    // Randomized fetches.
    for (int i = 0; i < 40; i++) begin
      int d;
      int ne;
      int f;
      d  = $urandom_range(0, 10);
      ne = (d < T) ? 3 + d : 2 + T;
      f  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ne - 1)) : -1;
      run_fetch(AW'($urandom), (DW - AW)'($urandom), $urandom, d, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
